conv_window_scheduler: RTL and testbench

Sequencing controller for the single-window convolution datapath. On `start` it scans every valid output position of an image of `img_size`×`img_size` pixels with a `filter_size`×`filter_size` filter. For each position it:
- issues the window's image-buffer reads;
- fires the window MAC engine and waits for its result;
- writes the result to the output feature buffer.

It sits between the layer-level control (start/done) and the image buffer, the window register file and the MAC engine.

---
 rtl/conv_window_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// conv_window_scheduler
//
// Sequencing controller for the single-window convolution datapath. After an
// accepted start it walks every valid output position of an img_size x
// img_size image with a filter_size x filter_size filter. For each position it
// streams the window's pixel reads into the window register file, fires the
// MAC engine, waits for its result and writes that result to the output
// feature buffer.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : pass request, accepted only while idle
//   abort        : return to idle from any state, no done pulse
//   img_size     : image side, latched on an accepted start
//   filter_size  : filter side (1, 3 or 5), latched on an accepted start
//   win_rd_en    : image-buffer read strobe
//   win_rd_addr  : image-buffer read address
//   win_idx      : destination slot in the window register file
//   mac_start    : one-cycle MAC engine trigger
//   mac_done     : MAC result valid
//   mac_result   : MAC result
//   out_wr_en    : output-buffer write strobe
//   out_wr_addr  : output-buffer write address
//   out_wr_data  : output-buffer write data
//   busy         : high in every state except idle
//   done         : one-cycle pulse at the end of a complete pass
//   cfg_err      : sticky configuration error, cleared by the next start
//
// Every output is a flop. The strobes are registered copies of the decoded
// next state, so they line up exactly with the state they belong to while no
// combinational path reaches an output from mac_done.
// ---------------------------------------------------------------------------
module conv_window_scheduler #(
  parameter int IMG_MAX  = 32,
  parameter int FILT_MAX = 5,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       img_size,
  input  logic [15:0]       filter_size,
  output logic              win_rd_en,
  output logic [ADDR_W-1:0] win_rd_addr,
  output logic [4:0]        win_idx,
  output logic              mac_start,
  input  logic              mac_done,
  input  logic [DATA_W-1:0] mac_result,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_FIRE    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_ADVANCE = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  // Row/column counters must hold 0..IMG_MAX-1.
  localparam int COUNT_W = $clog2(IMG_MAX) + 1;

  localparam logic [15:0]        IMG_MAX_W  = 16'(IMG_MAX);
  localparam logic [15:0]        FILT_MAX_W = 16'(FILT_MAX);
  localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_ZERO   = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_r;
  logic [2:0]         state_next_s;

  // Latched configuration and derived limits.
  logic [15:0]        img_r;
  logic [15:0]        k_r;
  logic [2:0]         k_last_r;      // K-1
  logic [COUNT_W-1:0] o_last_r;      // O-1

  // Position and window-offset counters.
  logic [COUNT_W-1:0] row_r;
  logic [COUNT_W-1:0] col_r;
  logic [2:0]         r_r;
  logic [2:0]         c_r;
  logic [4:0]         idx_r;

  // Running address arithmetic: no multipliers anywhere.
  logic [ADDR_W-1:0]  row_base_r;    // row * img_size
  logic [ADDR_W-1:0]  origin_r;      // row * img_size + col
  logic [ADDR_W-1:0]  rd_addr_r;     // current read address inside the window
  logic [ADDR_W-1:0]  out_addr_r;    // row * O + col

  logic [DATA_W-1:0]  result_r;
  logic               cfg_err_r;

  logic               win_rd_en_r;
  logic               mac_start_r;
  logic               out_wr_en_r;
  logic               busy_r;
  logic               done_r;

  logic               cfg_bad_s;
  logic               load_last_s;
  logic               pos_last_s;
  logic               col_wrap_s;
  logic [ADDR_W-1:0]  img_a_s;
  logic [ADDR_W-1:0]  row_step_s;
  logic [ADDR_W-1:0]  next_row_base_s;

  // Only odd filters up to FILT_MAX that fit inside an image no larger than
  // IMG_MAX give a valid pass.
  assign cfg_bad_s = ((k_r != 16'd1) && (k_r != 16'd3) && (k_r != 16'd5)) ||
                     (k_r > FILT_MAX_W) ||
                     (img_r < k_r) ||
                     (img_r > IMG_MAX_W);

  assign load_last_s     = (r_r == k_last_r) && (c_r == k_last_r);
  assign col_wrap_s      = (col_r == o_last_r);
  assign pos_last_s      = (row_r == o_last_r) && col_wrap_s;
  assign img_a_s         = ADDR_W'(img_r);
  // Moving from the end of one window row to the start of the next one.
  assign row_step_s      = img_a_s - {{(ADDR_W-3){1'b0}}, k_last_r};
  assign next_row_base_s = row_base_r + img_a_s;

  assign win_rd_en   = win_rd_en_r;
  assign win_rd_addr = rd_addr_r;
  assign win_idx     = idx_r;
  assign mac_start   = mac_start_r;
  assign out_wr_en   = out_wr_en_r;
  assign out_wr_addr = out_addr_r;
  assign out_wr_data = result_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign cfg_err     = cfg_err_r;

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_next_s = S_CHECK;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_CHECK: begin
          if (cfg_bad_s) begin
            state_next_s = S_FIN;
          end else begin
            state_next_s = S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_last_s) begin
            state_next_s = S_FIRE;
          end else begin
            state_next_s = S_LOAD;
          end
        end
        S_FIRE: begin
          state_next_s = S_WAIT;
        end
        S_WAIT: begin
          if (mac_done) begin
            state_next_s = S_WRITE;
          end else begin
            state_next_s = S_WAIT;
          end
        end
        S_WRITE: begin
          state_next_s = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (pos_last_s) begin
            state_next_s = S_FIN;
          end else begin
            state_next_s = S_LOAD;
          end
        end
        S_FIN: begin
          state_next_s = S_IDLE;
        end
        default: begin
          state_next_s = S_IDLE;
        end
      endcase
    end
  end

  // State register plus strobes registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      win_rd_en_r <= 1'b0;
      mac_start_r <= 1'b0;
      out_wr_en_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      win_rd_en_r <= (state_next_s == S_LOAD);
      mac_start_r <= (state_next_s == S_FIRE);
      out_wr_en_r <= (state_next_s == S_WRITE);
      busy_r      <= (state_next_s != S_IDLE);
      done_r      <= (state_next_s == S_FIN);
    end
  end

  // Configuration latch, counters, running addresses and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_r      <= 16'd0;
      k_r        <= 16'd0;
      k_last_r   <= 3'd0;
      o_last_r   <= CNT_ZERO;
      row_r      <= CNT_ZERO;
      col_r      <= CNT_ZERO;
      r_r        <= 3'd0;
      c_r        <= 3'd0;
      idx_r      <= 5'd0;
      row_base_r <= ADDR_ZERO;
      origin_r   <= ADDR_ZERO;
      rd_addr_r  <= ADDR_ZERO;
      out_addr_r <= ADDR_ZERO;
      result_r   <= {DATA_W{1'b0}};
      cfg_err_r  <= 1'b0;
    end else if (abort) begin
      // Counters are left as they are; CHECK reinitialises them on the next
      // pass, and cfg_err keeps its value across an abort.
      cfg_err_r <= cfg_err_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            img_r     <= img_size;
            k_r       <= filter_size;
            cfg_err_r <= 1'b0;
          end
        end
        S_CHECK: begin
          if (cfg_bad_s) begin
            cfg_err_r <= 1'b1;
          end else begin
            k_last_r   <= k_r[2:0] - 3'd1;
            // O-1 = img - 2*(K>>1) - 1, which is img - K for odd K.
            o_last_r   <= COUNT_W'(img_r - k_r);
            row_r      <= CNT_ZERO;
            col_r      <= CNT_ZERO;
            r_r        <= 3'd0;
            c_r        <= 3'd0;
            idx_r      <= 5'd0;
            row_base_r <= ADDR_ZERO;
            origin_r   <= ADDR_ZERO;
            rd_addr_r  <= ADDR_ZERO;
            out_addr_r <= ADDR_ZERO;
          end
        end
        S_LOAD: begin
          // The address is frozen on the window's final read so it never
          // steps past the last pixel of the image.
          if (c_r == k_last_r) begin
            c_r <= 3'd0;
            if (r_r != k_last_r) begin
              r_r       <= r_r + 3'd1;
              rd_addr_r <= rd_addr_r + row_step_s;
            end
          end else begin
            c_r       <= c_r + 3'd1;
            rd_addr_r <= rd_addr_r + ADDR_ONE;
          end
          if (!load_last_s) begin
            idx_r <= idx_r + 5'd1;
          end
        end
        S_WAIT: begin
          if (mac_done) begin
            result_r <= mac_result;
          end
        end
        S_ADVANCE: begin
          // On the final position everything holds, so no address wraps.
          if (!pos_last_s) begin
            r_r        <= 3'd0;
            c_r        <= 3'd0;
            idx_r      <= 5'd0;
            out_addr_r <= out_addr_r + ADDR_ONE;
            if (col_wrap_s) begin
              col_r      <= CNT_ZERO;
              row_r      <= row_r + CNT_ONE;
              row_base_r <= next_row_base_s;
              origin_r   <= next_row_base_s;
              rd_addr_r  <= next_row_base_s;
            end else begin
              col_r     <= col_r + CNT_ONE;
              origin_r  <= origin_r + ADDR_ONE;
              rd_addr_r <= origin_r + ADDR_ONE;
            end
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_window_scheduler
//
// Self-checking bench. A monitor process logs every read, write and done
// pulse at the falling edge and acts as the MAC engine, answering each
// mac_start after a random delay with random data. Each test task computes
// the expected read/write streams and cycle positions directly from the
// scan rules (nested row/col/r/c loops and the per-position cycle cost) and
// compares them with the logs.
// ---------------------------------------------------------------------------
module tb_conv_window_scheduler;

  localparam int IMG_MAX  = 32;
  localparam int FILT_MAX = 5;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 10;

  logic              clk;
  logic              reset;
  logic              start;
  logic              start_tb;
  logic              start_inj;
  logic              abort;
  logic [15:0]       img_size;
  logic [15:0]       filter_size;
  logic              win_rd_en;
  logic [ADDR_W-1:0] win_rd_addr;
  logic [4:0]        win_idx;
  logic              mac_start;
  logic              mac_done;
  logic [DATA_W-1:0] mac_result;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [DATA_W-1:0] out_wr_data;
  logic              busy;
  logic              done;
  logic              cfg_err;

  assign start = start_tb | start_inj;

  conv_window_scheduler #(
    .IMG_MAX (IMG_MAX),
    .FILT_MAX(FILT_MAX),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .img_size   (img_size),
    .filter_size(filter_size),
    .win_rd_en  (win_rd_en),
    .win_rd_addr(win_rd_addr),
    .win_idx    (win_idx),
    .mac_start  (mac_start),
    .mac_done   (mac_done),
    .mac_result (mac_result),
    .out_wr_en  (out_wr_en),
    .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Logs written only by the monitor; tests index them from a base.
  int rd_addr_q[$];
  int rd_idx_q[$];
  int rd_cyc_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int done_q[$];
  int mac_n_q[$];
  int mac_val_q[$];

  int mac_dmin = 1;
  int mac_dmax = 1;
  bit inject_start = 1'b0;
  int inj_state = 0;
  int inj_seen = 0;
  int inj_glitch = 0;
  int mac_cnt = 0;

  // Monitor and MAC-engine model.
  initial begin : monitor
    int n;
    mac_done   = 1'b0;
    mac_result = 16'h0000;
    start_inj  = 1'b0;
    forever begin
      @(negedge clk);
      if (win_rd_en) begin
        rd_addr_q.push_back(int'(win_rd_addr));
        rd_idx_q.push_back(int'(win_idx));
        rd_cyc_q.push_back(cyc);
      end
      if (out_wr_en) begin
        wr_addr_q.push_back(int'(out_wr_addr));
        wr_data_q.push_back(int'(out_wr_data));
        wr_cyc_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (inj_state == 1) begin
        inj_state = 2;
        start_inj = 1'b0;
        inj_seen++;
        if (!(busy && !win_rd_en && !out_wr_en && !mac_start && !done)) inj_glitch++;
      end
      mac_done   = 1'b0;
      mac_result = 16'($urandom);
      if (!reset) begin
        mac_cnt = 0;
      end else if (mac_cnt > 0) begin
        mac_cnt--;
        if (mac_cnt == 0) begin
          mac_done = 1'b1;
          mac_val_q.push_back(int'(mac_result));
        end else if (inject_start && inj_state == 0 && mac_cnt == 4) begin
          start_inj = 1'b1;
          inj_state = 1;
        end
      end
      if (mac_start) begin
        n = $urandom_range(mac_dmax, mac_dmin);
        mac_n_q.push_back(n);
        mac_cnt = n;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({win_rd_en, mac_start, out_wr_en, busy, done, cfg_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000",
               {win_rd_en, mac_start, out_wr_en, busy, done, cfg_err});
    end
    vectors++;
    if (win_rd_addr !== 10'd0 || win_idx !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_rd: got addr %0d idx %0d expected 0 0", win_rd_addr, win_idx);
    end
    vectors++;
    if (out_wr_addr !== 10'd0 || out_wr_data !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_wr: got addr %0d data %0d expected 0 0", out_wr_addr, out_wr_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || win_rd_en !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy %b rd_en %b done %b expected 0 0 0", busy, win_rd_en, done);
    end
  endtask

  task automatic test_window_pass(input int img, input int k, input int dmin, input int dmax,
                                  input bit inj);
    int s, rb, wb, db, mb, vb, o, npos, p, t, n, ok_wait, ea, ei, ec, ri;
    mac_dmin = dmin;
    mac_dmax = dmax;
    inject_start = inj;
    rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_q.size();
    mb = mac_n_q.size();   vb = mac_val_q.size();
    @(negedge clk); #1;
    img_size = 16'(img); filter_size = 16'(k); start_tb = 1'b1; s = cyc;
    @(negedge clk); #1;
    start_tb = 1'b0;
    ok_wait = 0;
    for (int i = 0; i < 40000; i++) begin
      if (done_q.size() > db) begin ok_wait = 1; break; end
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    #1;
    inject_start = 1'b0;
    o = img - 2 * (k / 2);
    npos = o * o;
    vectors++;
    if (ok_wait == 0) begin
      miscompares++;
      $display("FAIL pass_timeout: no done within 40000 cycles img=%0d k=%0d", img, k);
    end
    vectors++;
    if (wr_addr_q.size() - wb != npos) begin
      miscompares++;
      $display("FAIL write_count: got %0d expected %0d (img=%0d k=%0d)", wr_addr_q.size() - wb, npos, img, k);
    end
    vectors++;
    if (rd_addr_q.size() - rb != npos * k * k) begin
      miscompares++;
      $display("FAIL read_count: got %0d expected %0d (img=%0d k=%0d)", rd_addr_q.size() - rb, npos * k * k, img, k);
    end
    vectors++;
    if (mac_n_q.size() - mb != npos) begin
      miscompares++;
      $display("FAIL mac_start_count: got %0d expected %0d", mac_n_q.size() - mb, npos);
    end
    if (wr_addr_q.size() - wb == npos && rd_addr_q.size() - rb == npos * k * k &&
        mac_n_q.size() - mb == npos && mac_val_q.size() - vb >= npos && npos > 0) begin
      t = s + 2;
      p = 0;
      for (int row = 0; row < o; row++) begin
        for (int col = 0; col < o; col++) begin
          for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
              ri = rb + p * k * k + r * k + c;
              ea = (row + r) * img + col + c;
              ei = r * k + c;
              ec = t + r * k + c;
              vectors++;
              if (rd_addr_q[ri] != ea || rd_idx_q[ri] != ei || rd_cyc_q[ri] != ec) begin
                miscompares++;
                $display("FAIL read[%0d,%0d r%0d c%0d]: got addr %0d idx %0d cyc %0d expected %0d %0d %0d",
                         row, col, r, c, rd_addr_q[ri], rd_idx_q[ri], rd_cyc_q[ri], ea, ei, ec);
              end
            end
          end
          n = mac_n_q[mb + p];
          ea = row * o + col;
          ec = t + k * k + 1 + n;
          vectors++;
          if (wr_addr_q[wb + p] != ea || wr_data_q[wb + p] != mac_val_q[vb + p] || wr_cyc_q[wb + p] != ec) begin
            miscompares++;
            $display("FAIL write[%0d,%0d]: got addr %0d data %0d cyc %0d expected %0d %0d %0d",
                     row, col, wr_addr_q[wb + p], wr_data_q[wb + p], wr_cyc_q[wb + p],
                     ea, mac_val_q[vb + p], ec);
          end
          t = t + k * k + 3 + n;
          p++;
        end
      end
      vectors++;
      if (rd_addr_q[$] != img * img - 1 || wr_addr_q[$] != npos - 1) begin
        miscompares++;
        $display("FAIL last_addr: got rd %0d wr %0d expected %0d %0d",
                 rd_addr_q[$], wr_addr_q[$], img * img - 1, npos - 1);
      end
      vectors++;
      if (done_q.size() - db != 1 || done_q[db] != t) begin
        miscompares++;
        $display("FAIL done_timing: got count %0d cyc %0d expected 1 %0d",
                 done_q.size() - db, (done_q.size() > db) ? done_q[db] : -1, t);
      end
    end
    vectors++;
    if (busy !== 1'b0 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_end: got busy %b cfg_err %b expected 0 0", busy, cfg_err);
    end
    if (inj) begin
      vectors++;
      if (inj_seen != 1 || inj_glitch != 0) begin
        miscompares++;
        $display("FAIL wait_start: got seen %0d glitches %0d expected 1 0", inj_seen, inj_glitch);
      end
    end
  endtask

  task automatic test_random();
    int ks[3];
    int k, img;
    ks[0] = 1; ks[1] = 3; ks[2] = 5;
    for (int it = 0; it < 4; it++) begin
      k = ks[$urandom_range(2, 0)];
      img = $urandom_range(12, k);
      test_window_pass(img, k, 1, 4, 1'b0);
    end
  endtask

  task automatic test_cfg_err(input int img, input int k);
    int s, rb, wb, db, mb, ok_wait;
    mac_dmin = 1; mac_dmax = 1;
    rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_q.size(); mb = mac_n_q.size();
    @(negedge clk); #1;
    img_size = 16'(img); filter_size = 16'(k); start_tb = 1'b1; s = cyc;
    @(negedge clk); #1;
    start_tb = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (done_q.size() - db != 1 || done_q[db] != s + 2) begin
      miscompares++;
      $display("FAIL cfg_done: got count %0d cyc %0d expected 1 %0d img=%0d k=%0d",
               done_q.size() - db, (done_q.size() > db) ? done_q[db] : -1, s + 2, img, k);
    end
    vectors++;
    if (rd_addr_q.size() != rb || wr_addr_q.size() != wb || mac_n_q.size() != mb) begin
      miscompares++;
      $display("FAIL cfg_traffic: got rd %0d wr %0d mac %0d expected 0 0 0",
               rd_addr_q.size() - rb, wr_addr_q.size() - wb, mac_n_q.size() - mb);
    end
    vectors++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_flag: got cfg_err %b busy %b expected 1 0", cfg_err, busy);
    end
    @(negedge clk); #1;
    img_size = 16'd5; filter_size = 16'd1; start_tb = 1'b1;
    @(negedge clk); #1;
    start_tb = 1'b0;
    vectors++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_clear: got cfg_err %b busy %b expected 0 1", cfg_err, busy);
    end
    ok_wait = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin ok_wait = 1; break; end
      @(negedge clk); #1;
    end
    vectors++;
    if (ok_wait == 0) begin
      miscompares++;
      $display("FAIL cfg_recover_timeout: busy still %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int rb, wb, db, ok_wait;
    mac_dmin = 1; mac_dmax = 2;
    // Illegal pass first so cfg_err is set.
    @(negedge clk); #1;
    img_size = 16'd8; filter_size = 16'd4; start_tb = 1'b1;
    @(negedge clk); #1;
    start_tb = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // start together with abort in idle: start is dropped.
    db = done_q.size();
    img_size = 16'd6; filter_size = 16'd3; start_tb = 1'b1; abort = 1'b1;
    @(negedge clk); #1;
    start_tb = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || cfg_err !== 1'b1 || done_q.size() != db) begin
      miscompares++;
      $display("FAIL abort_start_idle: got busy %b cfg_err %b dones %0d expected 0 1 0",
               busy, cfg_err, done_q.size() - db);
    end
    // Legal pass, aborted during the load of position 3 (second read).
    rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_q.size();
    start_tb = 1'b1;
    @(negedge clk); #1;
    start_tb = 1'b0;
    ok_wait = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (rd_addr_q.size() - rb >= 29) begin ok_wait = 1; break; end
    end
    vectors++;
    if (ok_wait == 0 || win_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reach: got reads %0d rd_en %b expected 29 1", rd_addr_q.size() - rb, win_rd_en);
    end
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || win_rd_en !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy %b rd_en %b done %b expected 0 0 0", busy, win_rd_en, done);
    end
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (rd_addr_q.size() - rb != 29 || wr_addr_q.size() - wb != 3 || done_q.size() != db || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got reads %0d writes %0d dones %0d cfg_err %b expected 29 3 0 0",
               rd_addr_q.size() - rb, wr_addr_q.size() - wb, done_q.size() - db, cfg_err);
    end
  endtask

  task automatic test_reset_midpass();
    int wb, ok_wait;
    mac_dmin = 2; mac_dmax = 2;
    wb = wr_addr_q.size();
    @(negedge clk); #1;
    img_size = 16'd5; filter_size = 16'd3; start_tb = 1'b1;
    @(negedge clk); #1;
    start_tb = 1'b0;
    ok_wait = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (out_wr_en && wr_addr_q.size() - wb == 3) begin ok_wait = 1; break; end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (ok_wait == 0) begin
      miscompares++;
      $display("FAIL rst_reach: got writes %0d expected 3", wr_addr_q.size() - wb);
    end
    vectors++;
    if ({win_rd_en, mac_start, out_wr_en, busy, done, cfg_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_mid_flags: got %b expected 000000",
               {win_rd_en, mac_start, out_wr_en, busy, done, cfg_err});
    end
    vectors++;
    if (win_rd_addr !== 10'd0 || win_idx !== 5'd0 || out_wr_addr !== 10'd0 || out_wr_data !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_data: got rd %0d idx %0d wa %0d wd %0d expected 0 0 0 0",
               win_rd_addr, win_idx, out_wr_addr, out_wr_data);
    end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (wr_addr_q.size() - wb != 3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after: got writes %0d busy %b expected 3 0", wr_addr_q.size() - wb, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_tb = 1'b0;
    abort = 1'b0;
    img_size = 16'd0;
    filter_size = 16'd0;
    #2 reset = 1'b0;
    test_reset();
    test_window_pass(5, 3, 1, 1, 1'b0);
    test_window_pass(4, 1, 1, 1, 1'b0);
    test_window_pass(32, 5, 1, 3, 1'b0);
    test_random();
    test_cfg_err(8, 4);
    test_cfg_err(2, 3);
    test_cfg_err(33, 3);
    test_window_pass(5, 3, 7, 7, 1'b1);
    test_abort();
    test_reset_midpass();
    test_window_pass(5, 3, 1, 1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
